// File: rtl/image_container_bank_if.sv
// Write/read bus of the image row store: one write port spanning all banks, one read port per bank.
interface image_container_bank_if #(
  parameter int unsigned ROW_W = 3072,
  parameter int unsigned ROWS  = 128
);
  localparam int unsigned RA_W = $clog2(ROWS);
  localparam int unsigned WA_W = RA_W + 2;

  logic [RA_W-1:0]  raddr0;
  logic [RA_W-1:0]  raddr1;
  logic [RA_W-1:0]  raddr2;
  logic             re;
  logic [WA_W-1:0]  waddr;
  logic             we;
  logic [ROW_W-1:0] wdata;
  logic [ROW_W-1:0] rdata0;
  logic [ROW_W-1:0] rdata1;
  logic [ROW_W-1:0] rdata2;

  modport master (
    output raddr0, raddr1, raddr2, re, waddr, we, wdata,
    input  rdata0, rdata1, rdata2
  );

  modport slave (
    input  raddr0, raddr1, raddr2, re, waddr, we, wdata,
    output rdata0, rdata1, rdata2
  );
endinterface

// File: rtl/image_container_bank.sv
// Three-bank image row store: shared write port, per-bank registered read-first read port.
module image_container_bank #(
  parameter int unsigned ROW_W = 3072,
  parameter int unsigned ROWS  = 128,
  parameter int unsigned BANKS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  image_container_bank_if.slave bus
);
  localparam int unsigned RA_W   = $clog2(ROWS);
  localparam int unsigned BSEL_W = 2;

  logic [RA_W-1:0]   raddr_c [BANKS];
  logic [BSEL_W-1:0] wbank_c;
  logic [RA_W-1:0]   wrow_c;

  assign raddr_c[0] = bus.raddr0;
  assign raddr_c[1] = bus.raddr1;
  assign raddr_c[2] = bus.raddr2;
  assign wbank_c    = bus.waddr[RA_W +: BSEL_W];
  assign wrow_c     = bus.waddr[RA_W-1:0];

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    logic [ROW_W-1:0] mem_q [ROWS];
    logic [ROW_W-1:0] rdata_q;
    logic             wen_c;

    // Bank code 3 matches no bank, so such writes are silently dropped.
    assign wen_c = bus.we && (wbank_c == BSEL_W'(g));

    // Array is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
      if (wen_c) begin
        mem_q[wrow_c] <= bus.wdata;
      end
    end

    // rst_n is active-high here; reset wins over a read in the same cycle.
    always_ff @(posedge clk) begin
      if (rst_n) begin
        rdata_q <= '0;
      end else if (bus.re) begin
        rdata_q <= mem_q[raddr_c[g]];
      end
    end
  end

  assign bus.rdata0 = g_bank[0].rdata_q;
  assign bus.rdata1 = g_bank[1].rdata_q;
  assign bus.rdata2 = g_bank[2].rdata_q;
endmodule

// File: tb/tb_image_container_bank.sv
// Randomized self-checking bench for image_container_bank against a read-first array model.
module tb_image_container_bank;
  localparam int unsigned ROW_W = 3072;
  localparam int unsigned ROWS  = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [ROW_W-1:0] model [3][ROWS];
  logic [ROW_W-1:0] exp_rd [3];

  always #5 clk = ~clk;

  image_container_bank_if #(.ROW_W(ROW_W), .ROWS(ROWS)) bus ();

  image_container_bank #(.ROW_W(ROW_W), .ROWS(ROWS), .BANKS(3)) dut (
    .clk   (clk),
    .rst_n (rst),
    .bus   (bus)
  );

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < ROW_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] rd(input int b);
    case (b)
      0:       return bus.rdata0;
      1:       return bus.rdata1;
      default: return bus.rdata2;
    endcase
  endfunction

  // One clock: drive inputs, advance the model (reads see pre-write contents), then settle past the edge.
  task automatic drive(input logic r, input logic w, input logic [8:0] wa, input logic [ROW_W-1:0] wd,
                       input logic re, input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2);
    logic [6:0] ra [3];
    ra[0] = a0; ra[1] = a1; ra[2] = a2;
    rst = r; bus.we = w; bus.waddr = wa; bus.wdata = wd;
    bus.re = re; bus.raddr0 = a0; bus.raddr1 = a1; bus.raddr2 = a2;
    for (int b = 0; b < 3; b++) begin
      if (r) exp_rd[b] = '0;
      else if (re) exp_rd[b] = model[b][ra[b]];
    end
    if (w && wa[8:7] != 2'b11) model[wa[8:7]][wa[6:0]] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 9'h0, '0, 1'b0, 7'h0, 7'h0, 7'h0);
  endtask

  task automatic test_reset();
    logic [ROW_W-1:0] got;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 9'h0, '0, 1'b1, 7'($urandom), 7'($urandom), 7'($urandom));
      for (int b = 0; b < 3; b++) begin
        got = rd(b); total++;
        if (got !== '0) begin
          bad++; $display("FAIL reset_hold bank=%0d got=%h exp=0", b, got[63:0]);
        end
      end
    end
    // Fill every row with known data while re=0; outputs must stay cleared.
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < ROWS; r++)
        drive(1'b0, 1'b1, {2'(b), 7'(r)}, rand_row(), 1'b0, 7'($urandom), 7'($urandom), 7'($urandom));
    for (int b = 0; b < 3; b++) begin
      got = rd(b); total++;
      if (got !== '0) begin
        bad++; $display("FAIL reset_release bank=%0d got=%h exp=0", b, got[63:0]);
      end
    end
  endtask

  task automatic test_bank_write();
    logic [ROW_W-1:0] got;
    for (int wb = 0; wb < 3; wb++) begin
      drive(1'b0, 1'b1, {2'(wb), 7'h01}, '1, 1'b0, 7'h0, 7'h0, 7'h0);
      drive(1'b0, 1'b0, 9'h0, '0, 1'b1, 7'h01, 7'h01, 7'h01);
      for (int b = 0; b < 3; b++) begin
        got = rd(b); total++;
        if (got !== exp_rd[b]) begin
          bad++; $display("FAIL bank_write wb=%0d bank=%0d got=%h exp=%h", wb, b, got[63:0], exp_rd[b][63:0]);
        end
      end
      total++;
      if (rd(wb) !== '1) begin
        bad++; $display("FAIL bank_write_ones bank=%0d got=not-all-ones exp=all-ones", wb);
      end
    end
  endtask

  task automatic test_hold();
    logic [ROW_W-1:0] got;
    logic [6:0] a [3];
    drive(1'b0, 1'b0, 9'h0, '0, 1'b1, 7'd10, 7'd20, 7'd30);
    for (int c = 0; c < 3; c++) begin
      for (int b = 0; b < 3; b++) a[b] = 7'($urandom);
      drive(1'b0, 1'b1, {2'(c), a[c]}, rand_row(), 1'b0, a[0], a[1], a[2]);
      for (int b = 0; b < 3; b++) begin
        got = rd(b); total++;
        if (got !== exp_rd[b]) begin
          bad++; $display("FAIL hold c=%0d bank=%0d got=%h exp=%h", c, b, got[63:0], exp_rd[b][63:0]);
        end
      end
    end
    drive(1'b0, 1'b0, 9'h0, '0, 1'b1, a[0], a[1], a[2]);
    for (int b = 0; b < 3; b++) begin
      got = rd(b); total++;
      if (got !== exp_rd[b]) begin
        bad++; $display("FAIL hold_reread bank=%0d got=%h exp=%h", b, got[63:0], exp_rd[b][63:0]);
      end
    end
  endtask

  task automatic test_rdw();
    logic [ROW_W-1:0] pat_a;
    logic [ROW_W-1:0] got;
    pat_a = rand_row();
    drive(1'b0, 1'b1, 9'h005, '0, 1'b0, 7'h0, 7'h0, 7'h0);
    drive(1'b0, 1'b1, 9'h005, pat_a, 1'b1, 7'h05, 7'h05, 7'h05);
    got = rd(0); total++;
    if (got !== '0) begin
      bad++; $display("FAIL rdw_old got=%h exp=0", got[63:0]);
    end
    drive(1'b0, 1'b0, 9'h0, '0, 1'b1, 7'h05, 7'h05, 7'h05);
    got = rd(0); total++;
    if (got !== pat_a) begin
      bad++; $display("FAIL rdw_new got=%h exp=%h", got[63:0], pat_a[63:0]);
    end
  endtask

  task automatic test_invalid_bank();
    logic [ROW_W-1:0] pat_b;
    logic [ROW_W-1:0] got;
    pat_b = rand_row();
    drive(1'b0, 1'b1, 9'h181, pat_b, 1'b0, 7'h0, 7'h0, 7'h0);
    drive(1'b0, 1'b0, 9'h0, '0, 1'b1, 7'h01, 7'h01, 7'h01);
    for (int b = 0; b < 3; b++) begin
      got = rd(b); total++;
      if (got !== exp_rd[b] || got === pat_b) begin
        bad++; $display("FAIL invalid_bank bank=%0d got=%h exp=%h", b, got[63:0], exp_rd[b][63:0]);
      end
    end
  endtask

  task automatic test_independence();
    logic [ROW_W-1:0] got;
    logic [6:0] rows [3];
    rows[0] = 7'd0; rows[1] = 7'd64; rows[2] = 7'd127;
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < 3; r++)
        drive(1'b0, 1'b1, {2'(b), rows[r]}, rand_row(), 1'b0, 7'h0, 7'h0, 7'h0);
    for (int s = 0; s < 3; s++) begin
      drive(1'b0, 1'b0, 9'h0, '0, 1'b1, rows[s], rows[(s+1)%3], rows[(s+2)%3]);
      for (int b = 0; b < 3; b++) begin
        got = rd(b); total++;
        if (got !== exp_rd[b]) begin
          bad++; $display("FAIL independence s=%0d bank=%0d got=%h exp=%h", s, b, got[63:0], exp_rd[b][63:0]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [ROW_W-1:0] got;
    logic r;
    for (int c = 0; c < 300; c++) begin
      r = ($urandom_range(0, 19) == 0);
      drive(r, 1'($urandom), 9'($urandom), rand_row(), 1'($urandom),
            7'($urandom), 7'($urandom), 7'($urandom));
      for (int b = 0; b < 3; b++) begin
        got = rd(b); total++;
        if (got !== exp_rd[b]) begin
          bad++; $display("FAIL random c=%0d bank=%0d got=%h exp=%h", c, b, got[63:0], exp_rd[b][63:0]);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [ROW_W-1:0] pat;
    logic [ROW_W-1:0] got;
    pat = rand_row();
    drive(1'b0, 1'b0, 9'h0, '0, 1'b1, 7'd3, 7'd4, 7'd5);
    drive(1'b1, 1'b1, 9'h0A2, pat, 1'b1, 7'd3, 7'd4, 7'd5);
    for (int b = 0; b < 3; b++) begin
      got = rd(b); total++;
      if (got !== '0) begin
        bad++; $display("FAIL midop_reset bank=%0d got=%h exp=0", b, got[63:0]);
      end
    end
    drive(1'b0, 1'b0, 9'h0, '0, 1'b1, 7'd3, 7'h22, 7'd5);
    for (int b = 0; b < 3; b++) begin
      got = rd(b); total++;
      if (got !== exp_rd[b]) begin
        bad++; $display("FAIL midop_preserve bank=%0d got=%h exp=%h", b, got[63:0], exp_rd[b][63:0]);
      end
    end
    total++;
    if (rd(1) !== pat) begin
      bad++; $display("FAIL midop_write got=%h exp=%h", rd(1) & 64'hFFFF_FFFF_FFFF_FFFF, pat[63:0]);
    end
  endtask

  initial begin
    for (int b = 0; b < 3; b++) exp_rd[b] = '0;
    test_reset();
    test_bank_write();
    test_hold();
    test_rdw();
    test_invalid_bank();
    test_independence();
    test_random();
    test_reset_midop();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
